// File: rtl/zx_cpu_pkg.sv
// zx_cpu_pkg: shared definitions for the zx multi-cycle CPU.
//   state_t  - fetch / execute / memory FSM states
//   alu_op_t - ALU function select (codes match opcodes 0-8)
//   OP_*     - instruction opcodes (IR[15:12])
//   imm_from_rd - which opcodes take imm4 from IR[11:8]
package zx_cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_MUL = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7,
        ALU_SRA = 4'h8
    } alu_op_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_ADDI  = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JAL   = 4'hC;
    localparam logic [3:0] OP_JRL   = 4'hD;
    localparam logic [3:0] OP_BEQ   = 4'hE;
    localparam logic [3:0] OP_BLT   = 4'hF;

    // STORE and the branches use the rd slot as their immediate, since
    // they never write a register.
    function automatic logic imm_from_rd(input logic [3:0] op);
        return (op == OP_STORE) || (op == OP_BEQ) || (op == OP_BLT);
    endfunction

endpackage

// File: rtl/zx_alu.sv
// zx_alu: combinational ALU for the zx CPU.
//   op - function select (alu_op_t)
//   a  - first operand (rs1)
//   b  - second operand (rs2 or sign-extended immediate); shifts use
//        only its low $clog2(XLEN) bits
//   y  - result, XLEN bits (MUL keeps the low half)
module zx_alu
    import zx_cpu_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_MUL: y = a * b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << sh;
            ALU_SRL: y = a >> sh;
            ALU_SRA: y = $signed(a) >>> sh;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/zx_mc_cpu.sv
// zx_mc_cpu: 16-bit-instruction multi-cycle CPU (fetch / exec / mem).
//   i_clk, i_rst      - clock (rising edge), synchronous active-high reset
//   o_imem_*/i_imem_* - instruction port: req/addr held until ack
//   o_dmem_*/i_dmem_* - data port: req/we/addr/wdata held until ack
//   o_retire          - one-cycle pulse per completed instruction
//   o_pc              - architectural PC
module zx_mc_cpu
    import zx_cpu_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_rdata,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_retire,
    output logic [ADDR_W-1:0] o_pc
);

    localparam int AW_MIN = (XLEN < ADDR_W) ? XLEN : ADDR_W;
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [XLEN-1:0]   regs [16];

    // decode
    logic [3:0]      op, rd, rs1, rs2, imm4;
    logic [XLEN-1:0] imm, rs1_val, rs2_val;
    logic            is_alu, is_mem, is_store;

    assign op   = ir[15:12];
    assign rd   = ir[11:8];
    assign rs1  = ir[7:4];
    assign rs2  = ir[3:0];
    assign imm4 = imm_from_rd(op) ? ir[11:8] : ir[3:0];
    assign imm  = {{(XLEN-4){imm4[3]}}, imm4};

    assign rs1_val = (rs1 == 4'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 4'd0) ? '0 : regs[rs2];

    assign is_alu   = (op <= OP_SRA);
    assign is_store = (op == OP_STORE);
    assign is_mem   = (op == OP_LOAD) || is_store;

    // ALU: register ops use rs2; everything else (ADDI, load/store EA,
    // JAL/JRL target) is rs1 + imm.
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_b, alu_y;

    assign alu_op = is_alu ? alu_op_t'(op) : ALU_ADD;
    assign alu_b  = is_alu ? rs2_val : imm;

    zx_alu #(.XLEN(XLEN)) u_alu (
        .op (alu_op),
        .a  (rs1_val),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Crossing between data width and address width: truncate or
    // zero-extend, whichever applies.
    logic [ADDR_W-1:0] ea, pc_plus2, boff;
    logic [XLEN-1:0]   link;

    assign pc_plus2 = pc + ADDR_W'(2);
    assign boff     = {{(ADDR_W-5){imm4[3]}}, imm4, 1'b0};

    always_comb begin
        ea = '0;
        ea[AW_MIN-1:0] = alu_y[AW_MIN-1:0];
        link = '0;
        link[AW_MIN-1:0] = pc_plus2[AW_MIN-1:0];
    end

    // next PC for non-memory instructions
    logic [ADDR_W-1:0] pc_exec;

    always_comb begin
        pc_exec = pc_plus2;
        case (op)
            OP_JAL: pc_exec = ea;
            OP_JRL: pc_exec = pc + ea;
            OP_BEQ: if (rs1_val == rs2_val) pc_exec = pc + boff;
            OP_BLT: if ($signed(rs1_val) < $signed(rs2_val)) pc_exec = pc + boff;
            default: pc_exec = pc_plus2;
        endcase
    end

    // FSM
    logic              imem_req, dmem_req, retire;
    logic              ir_we, rf_we, pc_we;
    logic [XLEN-1:0]   rf_wdata;
    logic [ADDR_W-1:0] pc_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        retire    = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = alu_y;
        pc_we     = 1'b0;
        pc_nxt    = pc_plus2;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (i_imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_nxt = S_MEM;
                end else begin
                    rf_we     = (op != OP_BEQ) && (op != OP_BLT);
                    rf_wdata  = ((op == OP_JAL) || (op == OP_JRL)) ? link : alu_y;
                    pc_we     = 1'b1;
                    pc_nxt    = pc_exec;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (i_dmem_ack) begin
                    rf_we     = !is_store;
                    rf_wdata  = i_dmem_rdata;
                    pc_we     = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
        // Reset dominates: requests drop and a late ack cannot retire or
        // write anything in the reset cycle.
        if (i_rst) begin
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            retire    = 1'b0;
            ir_we     = 1'b0;
            rf_we     = 1'b0;
            pc_we     = 1'b0;
            state_nxt = S_FETCH;
        end
    end

    // datapath state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc <= PC_RST;
            ir <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (ir_we) ir <= i_imem_rdata;
            if (pc_we) pc <= {pc_nxt[ADDR_W-1:1], 1'b0};
            if (rf_we && (rd != 4'd0)) regs[rd] <= rf_wdata;
        end
    end

    // Operands come from IR and the register file, neither of which
    // changes while a transaction waits, so addr/wdata stay stable.
    assign o_imem_req   = imem_req;
    assign o_imem_addr  = imem_req ? pc : '0;
    assign o_dmem_req   = dmem_req;
    assign o_dmem_we    = dmem_req && is_store;
    assign o_dmem_addr  = dmem_req ? ea : '0;
    assign o_dmem_wdata = (dmem_req && is_store) ? rs2_val : '0;
    assign o_retire     = retire;
    assign o_pc         = pc;

endmodule

// File: tb/tb_zx_mc_cpu.sv
// tb_zx_mc_cpu: directed programs plus a random-instruction run, checked
// against an instruction-level reference interpreter.
module tb_zx_mc_cpu;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire;
    logic [15:0] o_pc;

    zx_mc_cpu dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .i_dmem_ack   (dmem_ack),
        .i_dmem_rdata (dmem_rdata),
        .o_retire     (retire),
        .o_pc         (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // memories (byte address indexes dmem directly, one word per address)
    logic [15:0] imem    [32768];
    logic [15:0] dmem    [65536];
    logic [15:0] mdl_mem [65536];

    typedef struct { logic [15:0] a; logic [15:0] d; } st_t;
    st_t         st_q[$];
    logic [15:0] hist[$];

    // responder config: wait cycles, -1 = random 0..3
    int iw_cfg, dw_cfg;
    bit d_force;
    int iw_cnt, dw_cnt, iw_need, dw_need;
    bit i_busy, d_busy;
    logic [15:0] i_addr0, d_addr0;

    // reference model
    logic [15:0] R [16];
    logic [15:0] mpc;
    bit          pend, p_mem, p_we;
    logic [15:0] p_addr, p_wdata;
    int          p_iw, p_dw;
    int          cyc = 0, last_ret = 0, nret = 0;

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    task automatic step(input logic [15:0] w);
        logic [3:0]  op, i4;
        logic [15:0] a, b, imm, res, npc;
        bit          wr;
        op  = w[15:12];
        a   = R[w[7:4]];
        b   = R[w[3:0]];
        i4  = (op == 4'hB || op == 4'hE || op == 4'hF) ? w[11:8] : w[3:0];
        imm = {{12{i4[3]}}, i4};
        res = 16'd0;
        wr  = 1'b1;
        npc = mpc + 16'd2;
        p_mem = 1'b0;
        p_we  = 1'b0;
        case (op)
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: res = a * b;
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = a ^ b;
            4'h6: res = a << b[3:0];
            4'h7: res = a >> b[3:0];
            4'h8: res = $signed(a) >>> b[3:0];
            4'h9: res = a + imm;
            4'hA: begin p_mem = 1'b1; p_addr = a + imm; res = mdl_mem[p_addr]; end
            4'hB: begin
                p_mem = 1'b1; p_we = 1'b1; p_addr = a + imm; p_wdata = b;
                mdl_mem[p_addr] = b; wr = 1'b0;
            end
            4'hC: begin res = mpc + 16'd2; npc = a + imm; end
            4'hD: begin res = mpc + 16'd2; npc = mpc + a + imm; end
            4'hE: begin wr = 1'b0; if (a == b) npc = mpc + (imm << 1); end
            default: begin wr = 1'b0; if ($signed(a) < $signed(b)) npc = mpc + (imm << 1); end
        endcase
        if (wr && w[11:8] != 4'd0) R[w[11:8]] = res;
        mpc  = npc & 16'hFFFE;
        pend = 1'b1;
        p_iw = iw_need;
    endtask

    // memory responder + monitor
    always @(negedge clk) begin
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        dmem_rdata = 16'($urandom);
        cyc++;
        if (rst) begin
            i_busy = 1'b0;
            d_busy = 1'b0;
        end else begin
            if (imem_req) begin
                if (!i_busy) begin i_busy = 1'b1; iw_cnt = 0; iw_need = pick(iw_cfg); i_addr0 = imem_addr; end
                if (iw_cnt == iw_need) begin
                    imem_ack = 1'b1; imem_rdata = imem[imem_addr[15:1]]; i_busy = 1'b0;
                end else iw_cnt++;
            end
            if (dmem_req) begin
                if (!d_busy) begin d_busy = 1'b1; dw_cnt = 0; dw_need = pick(dw_cfg); d_addr0 = dmem_addr; end
                if (dw_cnt == dw_need) begin
                    dmem_ack = 1'b1; dmem_rdata = dmem[dmem_addr]; d_busy = 1'b0;
                end else dw_cnt++;
            end
        end
        if (d_force) dmem_ack = 1'b1;
        #1;
        if (rst) begin
            for (int i = 0; i < 16; i++) R[i] = 16'd0;
            mpc = 16'd0; pend = 1'b0; last_ret = cyc;
        end else begin
            if (imem_req) chk("imem_addr_stable", imem_addr, i_addr0);
            if (imem_req && imem_ack) begin
                chk("fetch_pc", imem_addr, mpc);
                chk("o_pc", o_pc, mpc);
                chk("fetch_idle", pend, 0);
                hist.push_back(imem_addr);
                step(imem_rdata);
            end
            if (dmem_req) chk("dmem_addr_stable", dmem_addr, d_addr0);
            if (dmem_req && dmem_ack) begin
                chk("dmem_expected", p_mem, 1);
                chk("dmem_we", dmem_we, p_we);
                chk("dmem_addr", dmem_addr, p_addr);
                if (p_we) begin
                    chk("dmem_wdata", dmem_wdata, p_wdata);
                    dmem[dmem_addr] = dmem_wdata;
                    st_q.push_back('{dmem_addr, dmem_wdata});
                end
                p_dw = dw_need;
            end
            if (retire) begin
                chk("retire_expected", pend, 1);
                chk("cpi", cyc - last_ret, 2 + p_iw + (p_mem ? 1 + p_dw : 0));
                pend = 1'b0; last_ret = cyc; nret++;
            end
            chk("retire_gap_bound", (cyc - last_ret) <= 60, 1);
        end
    end

    function automatic logic [15:0] st_a(input int i);
        return (i < st_q.size()) ? st_q[i].a : 16'hxxxx;
    endfunction
    function automatic logic [15:0] st_d(input int i);
        return (i < st_q.size()) ? st_q[i].d : 16'hxxxx;
    endfunction
    function automatic logic [15:0] hist_at(input int i);
        return (i < hist.size()) ? hist[i] : 16'hxxxx;
    endfunction

    task automatic rst_on();
        rst = 1'b1;
        @(posedge clk); #2;
        st_q.delete();
        hist.delete();
        for (int i = 0; i < 64; i++) imem[i] = 16'hE000;
    endtask

    task automatic go(input int iw, input int dw, input int n);
        iw_cfg = iw;
        dw_cfg = dw;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; d_force = 1'b0; iw_cfg = 0; dw_cfg = 0;
        for (int i = 0; i < 65536; i++) begin dmem[i] = 16'd0; mdl_mem[i] = 16'd0; end
        for (int i = 0; i < 32768; i++) imem[i] = 16'hE000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_retire", retire, 0);
        chk("rst_pc", o_pc, 0);

        // ADDI/ADDI/ADD then store r3, zero wait
        rst_on();
        imem[0] = 16'h9105; imem[1] = 16'h920D; imem[2] = 16'h0312; imem[3] = 16'hB003;
        go(0, 0, 30);
        chk("t1_store_addr", st_a(0), 16'h0000);
        chk("t1_store_data", st_d(0), 16'h0002);

        // same program, fetch ack delayed 3 cycles
        rst_on();
        imem[0] = 16'h9105; imem[1] = 16'h920D; imem[2] = 16'h0312; imem[3] = 16'hB003;
        go(3, 0, 60);
        chk("t2_store_data", st_d(0), 16'h0002);
        chk("t2_nstores", st_q.size(), 1);

        // signed BLT taken, BEQ backwards
        rst_on();
        imem[0] = 16'h910F; imem[1] = 16'h9201; imem[2] = 16'hF212;
        imem[3] = 16'hB402; imem[4] = 16'hEF11;
        go(0, 0, 30);
        chk("t3_hist2", hist_at(3), 16'h0008);
        chk("t3_hist4", hist_at(4), 16'h0006);
        chk("t3_hist5", hist_at(5), 16'h0008);
        chk("t3_store_addr", st_a(0), 16'h0004);
        chk("t3_store_data", st_d(0), 16'h0001);

        // store/load round trip with 2 data wait cycles
        rst_on();
        dmem[6] = 16'h1234; mdl_mem[6] = 16'h1234;
        imem[0] = 16'hA206; imem[1] = 16'h9107; imem[2] = 16'h9117;
        imem[3] = 16'hB212; imem[4] = 16'hA412; imem[5] = 16'hB004;
        go(0, 2, 50);
        chk("t4_store_addr", st_a(0), 16'h0010);
        chk("t4_store_data", st_d(0), 16'h1234);
        chk("t4_load_back_addr", st_a(1), 16'h0000);
        chk("t4_load_back_data", st_d(1), 16'h1234);

        // r0 discard, JAL link and target
        rst_on();
        dmem[2] = 16'h0021; mdl_mem[2] = 16'h0021;
        imem[0] = 16'hA102; imem[1] = 16'h9007; imem[2] = 16'hB000; imem[3] = 16'hC510;
        imem[16] = 16'hB205; imem[17] = 16'hE000;
        go(0, 0, 40);
        chk("t5_r0_data", st_d(0), 16'h0000);
        chk("t5_jal_target", hist_at(4), 16'h0020);
        chk("t5_link_addr", st_a(1), 16'h0002);
        chk("t5_link_data", st_d(1), 16'h0008);

        // reset during pending load, late ack ignored
        rst_on();
        dmem[4] = 16'h5555; mdl_mem[4] = 16'h5555;
        imem[0] = 16'hA304;
        iw_cfg = 0; dw_cfg = 20;
        @(posedge clk); #2;
        rst = 1'b0;
        n = 0;
        while (!dmem_req && n < 20) begin @(posedge clk); #2; n++; end
        chk("t6_load_pending", dmem_req, 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        imem[0] = 16'hB003;
        @(posedge clk); #2;
        rst = 1'b0; d_force = 1'b1;
        st_q.delete(); hist.delete();
        @(negedge clk); #2;
        chk("t6_retire", retire, 0);
        chk("t6_dmem_req", dmem_req, 0);
        chk("t6_fetch_addr", imem_addr, 16'h0000);
        chk("t6_fetch_req", imem_req, 1);
        @(posedge clk); #2;
        d_force = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("t6_store_addr", st_a(0), 16'h0000);
        chk("t6_no_load_write", st_d(0), 16'h0000);

        // random instructions, random waits
        rst_on();
        for (int i = 0; i < 32768; i++) imem[i] = 16'($urandom);
        for (int i = 0; i < 65536; i++) begin dmem[i] = 16'($urandom); mdl_mem[i] = dmem[i]; end
        nret = 0;
        go(-1, -1, 4000);
        chk("rand_progress", nret > 300, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
